// File: rtl/pipe_tree_pkg.sv
// -----------------------------------------------------------------------------
// pipe_tree_pkg
//   Shared sizing helpers for the radix-6 pipelined trees (pipe_decode and
//   pipe_or). One tree level fits a single 6-input LUT. Because both pipelines
//   use the same latency function, they stay cycle-aligned for any WIDTH.
//
//   TREE_RADIX              fan-out of one tree level
//   pow6(n)                 6**n
//   pipe_latency(width)     number of registered levels for a given width
//   ceil_div(a, b)          integer ceiling division
//   level_groups(w, l, k)   enable bits held at level k of an l-level tree
//   level_offset(w, l, k)   bit offset of level k in a flattened level vector
// -----------------------------------------------------------------------------
package pipe_tree_pkg;

   localparam int TREE_RADIX = 6;

   function automatic int pow6(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) begin
         r = r * TREE_RADIX;
      end
      return r;
   endfunction

   function automatic int pipe_latency(input int width);
      if (width <= 6) begin
         return 1;
      end else if (width <= 36) begin
         return 2;
      end else if (width <= 216) begin
         return 3;
      end
      return 4;
   endfunction

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Level 0 is the single incoming valid bit: ceil(width / 6**lat) is 1 for
   // every width the latency function admits.
   function automatic int level_groups(input int width, input int lat, input int k);
      return ceil_div(width, pow6(lat - k));
   endfunction

   // Levels are packed back to back, level 0 at bit 0.
   function automatic int level_offset(input int width, input int lat, input int k);
      int off;
      off = 0;
      for (int i = 0; i < k; i++) begin
         off = off + level_groups(width, lat, i);
      end
      return off;
   endfunction

endpackage

// File: rtl/pipe_decode_if.sv
// -----------------------------------------------------------------------------
// pipe_decode_if
//   Index-in / one-hot-out bundle of pipe_decode.
//
//   din_valid   index valid this cycle
//   din         index to decode (SELW bits)
//   dout_valid  din_valid delayed by the decoder latency
//   dout        one-hot of din (WIDTH bits), zero when not valid
//   dout_err    with dout_valid: index was out of range, dout is zero
//
//   master: the index producer.  slave: the decoder.
// -----------------------------------------------------------------------------
interface pipe_decode_if #(
   parameter int WIDTH = 100
);

   localparam int SELW = $clog2(WIDTH);

   logic             din_valid;
   logic [SELW-1:0]  din;
   logic             dout_valid;
   logic [WIDTH-1:0] dout;
   logic             dout_err;

   modport master (
      output din_valid,
      output din,
      input  dout_valid,
      input  dout,
      input  dout_err
   );

   modport slave (
      input  din_valid,
      input  din,
      output dout_valid,
      output dout,
      output dout_err
   );

endinterface

// File: rtl/pipe_decode_stage.sv
// -----------------------------------------------------------------------------
// pipe_decode_stage
//   One registered level of the radix-6 decode tree. Output group j covers
//   index range [j*GSIZE, (j+1)*GSIZE) and is enabled when its parent group
//   (j/6 of the previous level) is enabled and the index falls in its range.
//   The index rides along so the next level sees it in the same cycle.
//
//   clk       clock, posedge
//   sclr_n    synchronous clear, active-low
//   en_i      enables of the previous level (IN_GROUPS bits)
//   idx_i     index as seen by the previous level
//   en_o      registered enables of this level (OUT_GROUPS bits)
//   idx_o     registered index, aligned with en_o
// -----------------------------------------------------------------------------
module pipe_decode_stage
   import pipe_tree_pkg::*;
#(
   parameter int IN_GROUPS  = 1,
   parameter int OUT_GROUPS = 6,
   parameter int GSIZE      = 1,
   parameter int SELW       = 3
) (
   input  logic                  clk,
   input  logic                  sclr_n,
   input  logic [IN_GROUPS-1:0]  en_i,
   input  logic [SELW-1:0]       idx_i,
   output logic [OUT_GROUPS-1:0] en_o,
   output logic [SELW-1:0]       idx_o
);

   logic [31:0]           idx_ext;
   logic [OUT_GROUPS-1:0] hit;
   logic [OUT_GROUPS-1:0] en_d;
   logic [OUT_GROUPS-1:0] en_q;
   logic [SELW-1:0]       idx_d;
   logic [SELW-1:0]       idx_q;

   // Compare at 32 bits so group bounds past the index range stay well-formed.
   assign idx_ext = 32'(idx_i);

   for (genvar j = 0; j < OUT_GROUPS; j++) begin : g_grp
      localparam logic [31:0] Hi = 32'((j + 1) * GSIZE);
      if (j == 0) begin : g_first
         assign hit[j] = (idx_ext < Hi);
      end else begin : g_rest
         localparam logic [31:0] Lo = 32'(j * GSIZE);
         assign hit[j] = (idx_ext >= Lo) && (idx_ext < Hi);
      end
   end

   always_comb begin
      en_d  = '0;
      idx_d = idx_i;
      for (int j = 0; j < OUT_GROUPS; j++) begin
         en_d[j] = en_i[j / TREE_RADIX] & hit[j];
      end
   end

   always_ff @(posedge clk) begin
      if (!sclr_n) begin
         en_q  <= '0;
         idx_q <= '0;
      end else begin
         en_q  <= en_d;
         idx_q <= idx_d;
      end
   end

   assign en_o  = en_q;
   assign idx_o = idx_q;

endmodule

// File: rtl/pipe_decode.sv
// -----------------------------------------------------------------------------
// pipe_decode
//   Pipelined binary-to-one-hot decoder built as a registered radix-6 tree.
//   LATENCY levels (1/2/3/4 for WIDTH <= 6/36/216/1296) so it lines up with
//   pipe_or of the same width. One index accepted per clock, no backpressure,
//   results in order. An out-of-range index yields dout=0 with dout_err set.
//
//   clk       clock, posedge
//   sclr_n    synchronous reset, active-low; clears every pipeline register
//   bus       pipe_decode_if.slave: din_valid/din in, dout_valid/dout/dout_err out
// -----------------------------------------------------------------------------
module pipe_decode
   import pipe_tree_pkg::*;
#(
   parameter int WIDTH = 100
) (
   input logic          clk,
   input logic          sclr_n,
   pipe_decode_if.slave bus
);

   localparam int SELW    = $clog2(WIDTH);
   localparam int LATENCY = pipe_latency(WIDTH);
   localparam int OUT_OFF = level_offset(WIDTH, LATENCY, LATENCY);
   localparam int EN_BITS = level_offset(WIDTH, LATENCY, LATENCY + 1);

   if (WIDTH < 2 || WIDTH > 1296) begin : g_bad_width
      $error("pipe_decode: WIDTH must be within 2..1296");
   end

   // All tree levels packed into one vector; level 0 is din_valid itself.
   logic [EN_BITS-1:0] en_all;
   logic [SELW-1:0]    idx_lvl [LATENCY+1];
   logic [LATENCY-1:0] vld_d;
   logic [LATENCY-1:0] vld_q;
   logic [31:0]        idx_out_ext;

   assign en_all[0]  = bus.din_valid;
   assign idx_lvl[0] = bus.din;

   for (genvar k = 1; k <= LATENCY; k++) begin : g_level
      localparam int InGroups  = level_groups(WIDTH, LATENCY, k - 1);
      localparam int OutGroups = level_groups(WIDTH, LATENCY, k);
      localparam int InOff     = level_offset(WIDTH, LATENCY, k - 1);
      localparam int OutOff    = level_offset(WIDTH, LATENCY, k);

      pipe_decode_stage #(
         .IN_GROUPS  (InGroups),
         .OUT_GROUPS (OutGroups),
         .GSIZE      (pow6(LATENCY - k)),
         .SELW       (SELW)
      ) u_stage (
         .clk    (clk),
         .sclr_n (sclr_n),
         .en_i   (en_all[InOff +: InGroups]),
         .idx_i  (idx_lvl[k-1]),
         .en_o   (en_all[OutOff +: OutGroups]),
         .idx_o  (idx_lvl[k])
      );
   end

   // Valid travels on its own chain so out-of-range slots still report valid.
   always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = bus.din_valid;
   end

   always_ff @(posedge clk) begin
      if (!sclr_n) begin
         vld_q <= '0;
      end else begin
         vld_q <= vld_d;
      end
   end

   assign idx_out_ext = 32'(idx_lvl[LATENCY]);

   // Last level has group size 1, so its enables are the one-hot itself.
   // Outputs depend only on flops; no input reaches them combinationally.
   assign bus.dout       = en_all[OUT_OFF +: WIDTH];
   assign bus.dout_valid = vld_q[LATENCY-1];
   assign bus.dout_err   = vld_q[LATENCY-1] & (idx_out_ext >= 32'(WIDTH));

endmodule
